// File: rtl/psg_multi.sv
// psg_multi: TONE_CH square-wave tone channels plus one LFSR noise channel, mixed and saturated.
// Latency: register writes land on the next cpuclk edge; sndout updates one cpuclk after each sound tick.
// Backpressure: none, every write strobe is accepted and the mixer runs free.
// Ports: cpuclk/reset (async, active-high); we/addr/wdata register bus; chmsk per-channel mix enable;
//        snd_tick tick pulse; sndout saturated mix; chactv channel attenuation != 4'hF.
// Optional: define PSG_LEGACY_BUS_EN to add the byte-wide latch/data bus lg_we/lg_data/lg_lreg
//           (needs TONE_CH >= 3 and FQ_W >= 10).
module psg_multi #(
  parameter int TONE_CH = 3,
  parameter int FQ_W = 10,
  parameter int PRESCALE = 16,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0F35,
  parameter logic [LFSR_W-1:0] WHITE_TAPS = 16'h8100,
  parameter logic [LFSR_W-1:0] PERIODIC_TAPS = 16'h4000,
  parameter int OUT_W = 8,
  parameter int GAIN_SH = 1,
  localparam int AW = $clog2(2*TONE_CH+2)
) (
  input  logic               cpuclk,
  input  logic               reset,
`ifdef PSG_LEGACY_BUS_EN
  input  logic               lg_we,
  input  logic [7:0]         lg_data,
  output logic [2:0]         lg_lreg,
`endif
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [FQ_W-1:0]    wdata,
  input  logic [TONE_CH:0]   chmsk,
  output logic               snd_tick,
  output logic [OUT_W-1:0]   sndout,
  output logic [TONE_CH:0]   chactv
);

  localparam int NCH   = TONE_CH + 1;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RAW_W = 6 + $clog2(TONE_CH+1);
  localparam int SW    = RAW_W + GAIN_SH;

  logic [PW-1:0]     pcnt;
  logic              tick;
  logic [FQ_W-1:0]   period [TONE_CH];
  logic [FQ_W-1:0]   tcnt [TONE_CH];
  logic [TONE_CH-1:0] tone_out;
  logic [3:0]        att_sh [NCH];
  logic [3:0]        att_act [NCH];
  logic [2:0]        nctl;
  logic [FQ_W-1:0]   ncnt;
  logic [LFSR_W-1:0] lfsr;

  logic [FQ_W-1:0]   period_nx [TONE_CH];
  logic [3:0]        att_nx [NCH];
  logic [2:0]        nctl_nx;
  logic              reseed;
  logic [FQ_W-1:0]   nper;
  logic [LFSR_W-1:0] taps;
  logic [NCH-1:0]    ch_on;
  logic [RAW_W-1:0]  raw_sum;
  logic [SW-1:0]     mix;
  logic [OUT_W-1:0]  mix_sat;

  function automatic logic [5:0] amp(input logic [3:0] att);
    case (att)
      4'h0: amp = 6'd63;
      4'h1: amp = 6'd50;
      4'h2: amp = 6'd40;
      4'h3: amp = 6'd32;
      4'h4: amp = 6'd25;
      4'h5: amp = 6'd20;
      4'h6: amp = 6'd16;
      4'h7: amp = 6'd13;
      4'h8: amp = 6'd10;
      4'h9: amp = 6'd8;
      4'hA: amp = 6'd6;
      4'hB: amp = 6'd5;
      4'hC: amp = 6'd4;
      4'hD: amp = 6'd3;
      4'hE: amp = 6'd2;
      default: amp = 6'd0;
    endcase
  endfunction

  assign tick = (pcnt == '0);

  // Register write decode. Legacy writes are applied first so that a
  // same-cycle write from the main bus to the same register overrides it.
  always_comb begin
    period_nx = period;
    att_nx    = att_sh;
    nctl_nx   = nctl;
    reseed    = 1'b0;
`ifdef PSG_LEGACY_BUS_EN
    if (lg_we) begin
      if (lg_data[7]) begin
        case (lg_data[6:4])
          3'd0: period_nx[0][3:0] = lg_data[3:0];
          3'd1: att_nx[0] = lg_data[3:0];
          3'd2: period_nx[1][3:0] = lg_data[3:0];
          3'd3: att_nx[1] = lg_data[3:0];
          3'd4: period_nx[2][3:0] = lg_data[3:0];
          3'd5: att_nx[2] = lg_data[3:0];
          3'd6: begin
            nctl_nx = lg_data[2:0];
            reseed  = 1'b1;
          end
          default: att_nx[TONE_CH] = lg_data[3:0];
        endcase
      end else begin
        case (lg_lreg)
          3'd0: period_nx[0][9:4] = lg_data[5:0];
          3'd2: period_nx[1][9:4] = lg_data[5:0];
          3'd4: period_nx[2][9:4] = lg_data[5:0];
          default: ;
        endcase
      end
    end
`endif
    if (we) begin
      for (int k = 0; k < TONE_CH; k++) begin
        if (addr == AW'(2*k))   period_nx[k] = wdata;
        if (addr == AW'(2*k+1)) att_nx[k]    = wdata[3:0];
      end
      if (addr == AW'(2*TONE_CH)) begin
        nctl_nx = wdata[2:0];
        reseed  = 1'b1;
      end
      if (addr == AW'(2*TONE_CH+1)) att_nx[TONE_CH] = wdata[3:0];
    end
  end

  // Noise reload value; rate 3 borrows the last tone's period with no DC override.
  always_comb begin
    case (nctl[1:0])
      2'd0:    nper = FQ_W'(64);
      2'd1:    nper = FQ_W'(128);
      2'd2:    nper = FQ_W'(256);
      default: nper = period[TONE_CH-1];
    endcase
  end

  assign taps  = nctl[2] ? WHITE_TAPS : PERIODIC_TAPS;
  assign ch_on = {lfsr[0], tone_out} & chmsk;

  always_comb begin
    raw_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_on[c]) raw_sum = raw_sum + RAW_W'(amp(att_act[c]));
    end
    mix = SW'(raw_sum) << GAIN_SH;
    if ((mix >> OUT_W) != '0) mix_sat = '1;
    else                      mix_sat = OUT_W'(mix);
  end

  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      pcnt     <= '0;
      snd_tick <= 1'b0;
      sndout   <= '0;
      chactv   <= '0;
      tone_out <= '0;
      for (int k = 0; k < TONE_CH; k++) begin
        period[k] <= '0;
        tcnt[k]   <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        att_sh[c]  <= 4'hF;
        att_act[c] <= 4'hF;
      end
      nctl <= '0;
      ncnt <= '0;
      lfsr <= LFSR_SEED;
`ifdef PSG_LEGACY_BUS_EN
      lg_lreg <= '0;
`endif
    end else begin
      pcnt     <= (pcnt == PW'(PRESCALE-1)) ? '0 : pcnt + PW'(1);
      snd_tick <= tick;
      for (int k = 0; k < TONE_CH; k++) period[k] <= period_nx[k];
      for (int c = 0; c < NCH; c++) begin
        att_sh[c] <= att_nx[c];
        chactv[c] <= (att_nx[c] != 4'hF);
      end
      nctl <= nctl_nx;
`ifdef PSG_LEGACY_BUS_EN
      if (lg_we && lg_data[7]) lg_lreg <= lg_data[6:4];
`endif
      // All tick updates read pre-edge state, so a write on a tick edge only
      // affects later ticks.
      if (tick) begin
        for (int c = 0; c < NCH; c++) att_act[c] <= att_sh[c];
        for (int k = 0; k < TONE_CH; k++) begin
          if (period[k] < FQ_W'(2)) begin
            tone_out[k] <= 1'b1;
            tcnt[k]     <= '0;
          end else if (tcnt[k] == '0) begin
            tcnt[k]     <= period[k];
            tone_out[k] <= ~tone_out[k];
          end else begin
            tcnt[k] <= tcnt[k] - FQ_W'(1);
          end
        end
        if (ncnt == '0) begin
          ncnt <= nper;
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? taps : '0);
        end else begin
          ncnt <= ncnt - FQ_W'(1);
        end
        sndout <= mix_sat;
      end
      // Reseed is last so it overrides a coincident noise shift.
      if (reseed) begin
        lfsr <= LFSR_SEED;
        ncnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_psg_multi.sv
module tb_psg_multi;
  localparam int TONE_CH = 3;
  localparam int FQ_W = 10;
  localparam int AW = 3;

  logic             cpuclk = 1'b0;
  logic             reset;
  logic             we;
  logic [AW-1:0]    addr;
  logic [FQ_W-1:0]  wdata;
  logic [TONE_CH:0] chmsk;
  logic             snd_tick;
  logic [7:0]       sndout;
  logic [TONE_CH:0] chactv;
`ifdef PSG_LEGACY_BUS_EN
  logic             lg_we;
  logic [7:0]       lg_data;
  logic [2:0]       lg_lreg;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state for the randomized phase
  int amp_t [16] = '{63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 2, 0};
  int m_per [3];
  int m_att [4];
  int m_nctl;
  int m_msk;

  psg_multi dut (
    .cpuclk  (cpuclk),
    .reset   (reset),
`ifdef PSG_LEGACY_BUS_EN
    .lg_we   (lg_we),
    .lg_data (lg_data),
    .lg_lreg (lg_lreg),
`endif
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .chmsk   (chmsk),
    .snd_tick(snd_tick),
    .sndout  (sndout),
    .chactv  (chactv)
  );

  always #5 cpuclk = ~cpuclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1;
    addr = AW'(a);
    wdata = FQ_W'(d);
    @(negedge cpuclk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    we = 1'b0;
    reset = 1'b1;
    @(negedge cpuclk);
    @(negedge cpuclk);
    reset = 1'b0;
  endtask

  // Returns at the negedge right after a tick edge (snd_tick high).
  task automatic wait_tick();
    int c = 0;
    do begin
      @(negedge cpuclk);
      c++;
    end while (snd_tick !== 1'b1 && c < 40);
    if (snd_tick !== 1'b1) chk("tick_timeout", snd_tick, 1);
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v, input logic [15:0] t);
    return (v >> 1) ^ (v[0] ? t : 16'h0000);
  endfunction

  // Tone output after tick n when the period is written between tick 1 and tick 2.
  function automatic int tone_m(input int p, input int n);
    if (p < 2 || n == 1) return 1;
    return ((n - 2) / (p + 1)) % 2;
  endfunction

  // Noise output after tick n (n >= 2) when control is written between tick 1 and tick 2.
  function automatic int noise_m(input int n);
    int np;
    int k;
    logic [15:0] v;
    logic [15:0] t;
    np = ((m_nctl & 3) == 3) ? m_per[2] : (64 << (m_nctl & 3));
    t = ((m_nctl & 4) != 0) ? 16'h8100 : 16'h4000;
    k = 1 + (n - 2) / (np + 1);
    v = 16'h0F35;
    for (int i = 0; i < k; i++) v = lstep(v, t);
    return int'(v[0]);
  endfunction

  function automatic int exp_snd(input int n);
    int s = 0;
    int m = n - 1;
    for (int k = 0; k < 3; k++)
      if (((m_msk >> k) & 1) == 1 && tone_m(m_per[k], m) == 1) s += amp_t[m_att[k]];
    if (((m_msk >> 3) & 1) == 1 && noise_m(m) == 1) s += amp_t[m_att[3]];
    s = s << 1;
    return (s > 255) ? 255 : s;
  endfunction

  initial begin
    int npulse;
    int last;
    int first;
    int gap_bad;
    int cnt;
    int ech;
    int pat [12];
    logic [15:0] prev;

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; chmsk = '0;
`ifdef PSG_LEGACY_BUS_EN
    lg_we = 1'b0; lg_data = '0;
`endif
    pat = '{0, 0, 0, 126, 126, 126, 0, 0, 0, 126, 126, 126};

    // Reset state and idle tick cadence
    @(negedge cpuclk);
    chk("rst_sndout", sndout, 0);
    chk("rst_chactv", chactv, 0);
    chk("rst_tick", snd_tick, 0);
    reset = 1'b0;
    npulse = 0; last = -1; first = -1; gap_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge cpuclk);
      if (snd_tick === 1'b1) begin
        if (last >= 0 && i - last != 16) gap_bad++;
        if (last < 0) first = i;
        last = i;
        npulse++;
      end
    end
    chk("idle_first_tick", first, 1);
    chk("idle_pulses", npulse, 7);
    chk("idle_gap_err", gap_bad, 0);
    chk("idle_sndout", sndout, 0);
    chk("idle_chactv", chactv, 0);

    // Tone 0 period 2: toggles every 3 ticks
    do_reset();
    wait_tick();
    chmsk = 4'b0001;
    wr(0, 2);
    wr(1, 0);
    chk("t2_chactv", chactv, 4'b0001);
    wait_tick();
    chk("t2_tick2_sndout", sndout, 0);
    for (int i = 0; i < 12; i++) begin
      wait_tick();
      chk("t2_pattern", sndout, pat[i]);
    end

    // Saturation, then attenuation change visible on the second tick
    do_reset();
    wait_tick();
    chmsk = 4'hF;
    wr(0, 1); wr(2, 1); wr(4, 1);
    wr(1, 0); wr(3, 0); wr(5, 0); wr(7, 15);
    wait_tick();
    wait_tick();
    chk("sat_sndout", sndout, 255);
    chk("sat_chactv", chactv, 4'b0111);
    wr(3, 15);
    wait_tick();
    chk("att_1tick", sndout, 255);
    wait_tick();
    chk("att_2tick", sndout, 252);

    // White noise rate 0: first shift and interval
    do_reset();
    wait_tick();
    chmsk = 4'b1000;
    wr(7, 0);
    wr(6, 4);
    chk("noise_reseed", dut.lfsr, 16'h0F35);
    wait_tick();
    chk("noise_first", dut.lfsr, 16'h869A);
    prev = dut.lfsr;
    cnt = 0;
    do begin
      wait_tick();
      cnt++;
    end while (dut.lfsr == prev && cnt < 100);
    chk("noise_interval", cnt, 65);
    chk("noise_second", dut.lfsr, lstep(16'h869A, 16'h8100));

    // Writes coinciding with a tick
    do_reset();
    wait_tick();
    chmsk = 4'b0001;
    wr(0, 1);
    wr(1, 0);
    wr(6, 7);
    wait_tick(); wait_tick(); wait_tick();
    repeat (15) @(negedge cpuclk);
    wr(6, 7);
    chk("nctl_on_tick", snd_tick, 1);
    chk("reseed_wins", dut.lfsr, 16'h0F35);
    wait_tick();
    chk("shift_after_reseed", dut.lfsr, 16'h869A);
    repeat (15) @(negedge cpuclk);
    wr(0, 4);
    chk("per_on_tick", snd_tick, 1);
    wait_tick();
    chk("per_old_used", sndout, 126);
    wait_tick();
    chk("per_new_used", sndout, 0);

    // Asynchronous reset in the middle of a tone
    do_reset();
    wait_tick();
    chmsk = 4'b0001;
    wr(0, 2);
    wr(1, 0);
    cnt = 0;
    do begin
      wait_tick();
      cnt++;
    end while (sndout !== 8'd126 && cnt < 20);
    chk("pre_reset_sndout", sndout, 126);
    #2;
    reset = 1'b1;
    #1;
    chk("async_sndout", sndout, 0);
    chk("async_chactv", chactv, 0);
    chk("async_tick", snd_tick, 0);
    @(negedge cpuclk);
    reset = 1'b0;
    #1;
    chk("post_rst_lfsr", dut.lfsr, 16'h0F35);
    chk("post_rst_pcnt", dut.pcnt, 0);

    // Randomized configurations against the reference model
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) m_per[k] = $urandom_range(0, 1);
        else                           m_per[k] = $urandom_range(2, 12);
      end
      for (int c = 0; c < 4; c++) m_att[c] = $urandom_range(0, 15);
      m_nctl = $urandom_range(0, 7);
      m_msk = $urandom_range(0, 15);
      do_reset();
      wait_tick();
      chmsk = 4'(m_msk);
      wr(0, m_per[0]); wr(2, m_per[1]); wr(4, m_per[2]);
      wr(1, m_att[0]); wr(3, m_att[1]); wr(5, m_att[2]); wr(7, m_att[3]);
      wr(6, m_nctl);
      ech = 0;
      for (int c = 0; c < 4; c++) if (m_att[c] != 15) ech |= (1 << c);
      chk("rnd_chactv", chactv, ech);
      wait_tick();
      for (int n = 3; n <= 150; n++) begin
        wait_tick();
        chk("rnd_sndout", sndout, exp_snd(n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psg_multi.md
Name: psg_multi

Overview:
Parametrised square-wave programmable sound generator with TONE_CH tone channels and one LFSR noise channel. It is the successor to the team's fixed 3+1-channel SN-style PSG, and uses a flat register-addressed bus clocked by cpuclk. Relative to that block it adds:
- a configurable counter width, output width and mixer gain
- a DC mode for periods 0 and 1
- LFSR reseed on every noise-control write
- a single clock domain, with an internal prescaler generating the sound tick

Parameters:
TONE_CH, 3, number of tone channels (1..8); the noise channel index is TONE_CH.
FQ_W, 10, tone period / counter width in bits (>=9).
PRESCALE, 16, cpuclk cycles per sound tick (>=2).
LFSR_W, 16, noise shift register width.
LFSR_SEED, 16'h0F35, LFSR reset/reseed value (LFSR_W bits).
WHITE_TAPS, 16'h8100, feedback XOR mask for white noise.
PERIODIC_TAPS, 16'h4000, feedback XOR mask for periodic noise.
OUT_W, 8, mixed output width.
GAIN_SH, 1, left shift applied to the mix sum before saturation.

Ports:
cpuclk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
we  in  1  register write strobe, one cpuclk per write.
addr  in  AW=$clog2(2*TONE_CH+2)  register address.
wdata  in  FQ_W  write data.
chmsk  in  TONE_CH+1  per-channel mix enable; bit TONE_CH is noise.
snd_tick  out  1  one-cpuclk pulse on every sound tick.
sndout  out  OUT_W  saturated mix.
chactv  out  TONE_CH+1  channel active flag = attenuation register != 4'hF.

Behaviour:
Reset: every output and register is cleared asynchronously.
- sndout=0, chactv=0, snd_tick=0.
- Periods=0, tone counters=0, tone outputs=0.
- Shadow and active attenuations=4'hF. Amplitude for 4'hF is 0.
- Noise control=0, noise counter=0, LFSR=LFSR_SEED, prescaler=0.
- Reset asserted mid-operation aborts all activity immediately. No partial write survives.

Register map:
- Address 2k: tone k period, wdata[FQ_W-1:0].
- Address 2k+1: tone k attenuation, wdata[3:0].
- Address 2*TONE_CH: noise control, wdata[2:0]. Bit 2: 1=white, 0=periodic. Bits [1:0]: rate.
- Address 2*TONE_CH+1: noise attenuation, wdata[3:0].
- Addresses >= 2*TONE_CH+2 are ignored.
- Writes land on the cpuclk edge. chactv updates on the same edge.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- The tick is asserted when the count is 0. snd_tick is registered, so the pulse appears one cycle later.

On each tick, all updates use the pre-edge register values:
- Active attenuations are loaded from the shadow registers.
- Tone k, period P >= 2: if counter==0, reload P and toggle the output. Otherwise decrement. The output toggles every P+1 ticks.
- Tone k, period 0 or 1: the output is forced to 1 (DC) and the counter is held at 0.
- Noise period: rate 0/1/2 selects 64/128/256. Rate 3 selects the period register of tone TONE_CH-1, with no DC override.
- Noise step: if counter==0, reload the period and shift the LFSR as lfsr = (lfsr>>1) XOR (lfsr[0] ? taps : 0). Otherwise decrement.
- The noise output is lfsr[0].
- Mix: each channel contributes amp(att) when its output=1 and its chmsk bit=1. The amp table for att 0..F is 63,50,40,32,25,20,16,13,10,8,6,5,4,3,2,0.
- S = sum of contributions, shifted left by GAIN_SH, computed in 6+$clog2(TONE_CH+1)+GAIN_SH bits.
- sndout = S if S < 2^OUT_W, else all ones.
- sndout uses the pre-edge tone outputs and active amplitudes. An attenuation write is therefore visible in sndout on the second tick after the write.

Simultaneous events:
- A period write does not touch the counter. The new value is used at the next reload.
- A noise-control write reloads LFSR_SEED and clears the noise counter. If it coincides with a tick, the reseed wins over the shift.
- A write on a tick cycle affects only later ticks.

Optional Feature:
Macro: PSG_LEGACY_BUS_EN.
With the macro defined:
- Extra ports lg_we (in, 1) and lg_data (in, 8).
- Extra output lg_lreg (out, 3), reset 0.
- lg_data[7]=1 is a latch byte: lg_lreg<=[6:4]. Registers 0/2/4 take period[3:0]. Registers 1/3/5/7 take attenuation for tone 0/1/2 and noise. Register 6 takes noise control (with reseed).
- lg_data[7]=0 is a data byte: for lg_lreg 0/2/4, period[9:4]<=[5:0]; otherwise ignored.
- Legacy accesses map to tones 0..2 and noise only.
- If we and lg_we hit the same register in the same cycle, the we write wins.
Without the macro: these ports and all legacy logic are absent.

Test Plan:
1. Reset, then 100 cpuclk idle -> sndout=0, chactv=0, snd_tick pulses every 16 cpuclk.
2. Tone0 period=2, att=0, chmsk=4'b0001 -> tone0 toggles every 3 ticks (48 cpuclk); sndout alternates 0/126; chactv=4'b0001.
3. All tones period=1, noise att=F, tone att=0, chmsk=4'hF -> S=378, sndout saturates at 255. Then set tone1 att=F -> after 2 ticks S=252, sndout=252.
4. Noise control=3'b100 (white, rate 0), noise att=0, chmsk=4'b1000 -> first tick LFSR 0x0F35->0x869A; next shift exactly 65 ticks later.
5. Noise control write on the same cpuclk as a tick -> LFSR reads 0x0F35 after the edge with no shift; tone0 period write on a tick -> old period used for that tick.
6. Reset asserted mid-tone with sndout=126 -> sndout=0 asynchronously; LFSR=0x0F35 and prescaler=0 after release.
